// File: rtl/seq_divider_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// start is a one-cycle launch request, honoured only while busy is low; done pulses for one cycle with result valid.
interface seq_divider_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    modport master (
        output start, op, dividend, divisor, flush,
        input  busy, done, result, dbg_state
    );

    modport slave (
        input  start, op, dividend, divisor, flush,
        output busy, done, result, dbg_state
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// The divider works on magnitudes, and signs are applied in a single fix-up cycle.
module seq_divider (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_n;
    logic        accept;
    logic [5:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] divs;
    logic        op_rem;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] result;

    logic        is_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        div_zero;
    logic        ovf;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign is_signed = ~bus.op[0];
    assign abs_a     = (is_signed && bus.dividend[31]) ? (~bus.dividend + 32'd1) : bus.dividend;
    assign abs_b     = (is_signed && bus.divisor[31])  ? (~bus.divisor + 32'd1)  : bus.divisor;
    assign div_zero  = (bus.divisor == 32'd0);
    assign ovf       = is_signed && (bus.dividend == 32'h8000_0000) && (bus.divisor == 32'hFFFF_FFFF);

    // Subtraction as an add of the inverted divisor with carry-in 1; bit 32 is the borrow/sign.
    assign rem_sh = {rem, quo[31]};
    assign trial  = rem_sh + {1'b1, ~divs} + 33'd1;

    assign q_fix = neg_q ? (~quo + 32'd1) : quo;
    assign r_fix = neg_r ? (~rem + 32'd1) : rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (bus.start) begin
                    accept  = 1'b1;
                    state_n = (div_zero || ovf) ? DONE : CALC;
                end
            end
            CALC:    if (cnt == 6'd31) state_n = FIX;
            FIX:     state_n = DONE;
            default: state_n = IDLE;
        endcase
        if (bus.flush) begin
            accept  = 1'b0;
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 6'd0;
            rem    <= 32'd0;
            quo    <= 32'd0;
            divs   <= 32'd0;
            op_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= 32'd0;
        end else if (accept) begin
            op_rem <= bus.op[1];
            neg_q  <= is_signed && (bus.dividend[31] ^ bus.divisor[31]);
            neg_r  <= is_signed && bus.dividend[31];
            divs   <= abs_b;
            quo    <= abs_a;
            rem    <= 32'd0;
            cnt    <= 6'd0;
            // Special cases bypass the iteration and settle result right away.
            if (div_zero) begin
                result <= bus.op[1] ? bus.dividend : 32'hFFFF_FFFF;
            end else if (ovf) begin
                result <= bus.op[1] ? 32'd0 : 32'h8000_0000;
            end
        end else if (state == CALC && !bus.flush) begin
            rem <= trial[32] ? rem_sh[31:0] : trial[31:0];
            quo <= {quo[30:0], ~trial[32]};
            cnt <= cnt + 6'd1;
        end else if (state == FIX && !bus.flush) begin
            result <= op_rem ? r_fix : q_fix;
        end
    end

    assign bus.busy      = (state == CALC) || (state == FIX);
    assign bus.done      = (state == DONE);
    assign bus.result    = result;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases from the plan plus random ops, scored against an arithmetic model.
module tb_seq_divider;
    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    logic mon_en;

    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] exp_res;
    int          busy_lo;
    int          busy_hi;

    seq_divider_if bus ();

    seq_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and cycle counter; cycle N is the interval after the Nth rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        sa = a;
        sb = b;
        case (op)
            2'd0:    return sa / sb;
            2'd1:    return a / b;
            2'd2:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // Driver tasks: all called just after a rising edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int c;
        c = cyc;
        bus.start    = 1'b1;
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        exp_q.push_back(ref_div(op, a, b));
        if (is_special(op, a, b)) begin
            exp_cyc_q.push_back(c + 1);
        end else begin
            exp_cyc_q.push_back(c + 34);
            busy_lo = c + 1;
            busy_hi = c + 33;
        end
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.op       = 2'($urandom_range(0, 3));
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: pending=%0d at cycle %0d, required 0 pending", exp_q.size(), cyc);
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    // Monitor: per-cycle busy window, result hold, and scoreboard pop on done.
    always @(negedge clk) begin
        logic        exp_busy;
        logic [31:0] e;
        int          ec;
        if (mon_en) begin
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            checks++;
            if (bus.busy !== exp_busy) begin
                failures++;
                $display("FAIL busy: cycle %0d got %b required %b", cyc, bus.busy, exp_busy);
            end
            if (bus.done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: cycle %0d got done=1 required 0", cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    if (bus.result !== e) begin
                        failures++;
                        $display("FAIL result: cycle %0d got %h required %h", cyc, bus.result, e);
                    end
                    checks++;
                    if (cyc != ec) begin
                        failures++;
                        $display("FAIL done_cycle: got cycle %0d required cycle %0d", cyc, ec);
                    end
                    exp_res = e;
                end
            end else begin
                checks++;
                if (bus.done !== 1'b0) begin
                    failures++;
                    $display("FAIL done_level: cycle %0d got %b required 0", cyc, bus.done);
                end
            end
            checks++;
            if (bus.result !== exp_res) begin
                failures++;
                $display("FAIL result_hold: cycle %0d got %h required %h", cyc, bus.result, exp_res);
            end
        end
    end

    initial begin
        int c;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        checks       = 0;
        failures     = 0;
        mon_en       = 1'b0;
        exp_res      = 32'd0;
        busy_lo      = 1;
        busy_hi      = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.op       = 2'd0;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Unsigned and signed basics.
        issue(2'd1, 32'd100, 32'd7);          wait_done();
        issue(2'd3, 32'd100, 32'd7);          wait_done();
        issue(2'd0, 32'hFFFF_FFF9, 32'd2);    wait_done();
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);    wait_done();
        issue(2'd2, 32'd7, 32'hFFFF_FFFE);    wait_done();

        // Divide by zero and signed overflow, including back-to-back special cases.
        issue(2'd1, 32'd5, 32'd0);            wait_done();
        issue(2'd2, 32'hFFFF_FFFB, 32'd0);    wait_done();
        issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'd0, 32'd42, 32'd0);
        wait_done();
        issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();

        // Flush in cycle 10: no done, result unchanged, busy low from cycle 11.
        c = cyc;
        issue(2'd1, 32'd1000, 32'd3);
        wait_until(c + 10);
        bus.flush = 1'b1;
        busy_hi   = c + 10;
        void'(exp_q.pop_back());
        void'(exp_cyc_q.pop_back());
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // Start during CALC is ignored.
        c = cyc;
        issue(2'd1, 32'd1000, 32'd3);
        wait_until(c + 5);
        bus.start    = 1'b1;
        bus.op       = 2'd0;
        bus.dividend = 32'd77;
        bus.divisor  = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done();

        // Reset mid-operation.
        c = cyc;
        issue(2'd1, 32'd12345, 32'd7);
        wait_until(c + 20);
        rst     = 1'b1;
        busy_hi = c + 20;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        exp_res = 32'd0;
        repeat (4) @(posedge clk);
        #1;

        // Back-to-back: second start in the DONE cycle of the first.
        c = cyc;
        issue(2'd1, 32'd9, 32'd3);
        wait_until(c + 34);
        issue(2'd3, 32'd10, 32'd4);
        wait_done();

        // Random ops, sometimes chained back-to-back.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            issue(op, a, b);
            if ($urandom_range(0, 1) == 0) wait_done();
            else wait_until(exp_cyc_q[$]);
        end
        wait_done();
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
